// File: rtl/roulette_pkg.sv
// Shared definitions for the roulette round controller.
// Provides key opcodes, round-state encodings, bus widths and the
// bet-table entry layout used by bet_round_controller and hold_timer.
package roulette_pkg;

  localparam int unsigned OPC_W    = 6;
  localparam int unsigned CHIP_W   = 3;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned TMR_W    = 32;
  localparam int unsigned MAX_BETS = 12;

  localparam logic [OPC_W-1:0] OPC_SPIN = 6'b111110;
  localparam logic [OPC_W-1:0] OPC_NONE = 6'b111111;

  typedef enum logic [1:0] {
    ST_BETTING  = 2'd0,
    ST_SPINNING = 2'd1,
    ST_SETTLE   = 2'd2
  } round_state_e;

  // One bet-table slot: chip amount code above the target opcode.
  typedef struct packed {
    logic [1:0]       amount;
    logic [OPC_W-1:0] opcode;
  } bet_entry_t;

endpackage

// File: rtl/bet_round_controller_hold_timer.sv
// hold_timer: reloadable down-counter.
//   i_clock     : clock
//   i_reset     : async active-high reset
//   i_load      : (re)load counter with CYCLES
//   o_busy      : registered, high for exactly CYCLES cycles after the last load
//   o_expire_c  : combinational, high in the final counting cycle (the edge
//                 that ends it brings the count to zero)
module hold_timer
  import roulette_pkg::*;
#(
  parameter int unsigned CYCLES = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  output logic o_busy,
  output logic o_expire_c
);

  logic [TMR_W-1:0] r_cnt;
  logic             r_busy;

  // Count down to zero; a load always wins so retriggers leave no gap.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= TMR_W'(CYCLES);
      r_busy <= (CYCLES != 0);
    end else begin
      if (r_cnt != '0) r_cnt <= r_cnt - TMR_W'(1);
      r_busy <= (r_cnt > TMR_W'(1));
    end
  end

  assign o_busy     = r_busy;
  assign o_expire_c = (r_cnt == TMR_W'(1)) && !i_load;

endmodule

// File: rtl/bet_round_controller.sv
// bet_round_controller: sequences one roulette round.
//   i_clock/i_reset      : clock, async active-high reset
//   i_key_valid          : strobe, decoded key on i_bet_opcode
//   i_bet_opcode         : bet target, SPIN or NONE
//   i_chip_color         : [2] chip present, [1:0] amount code
//   i_spin_done          : payout computed, ends SPINNING
//   o_bet_wr_en/idx/data : bet-table write port
//   o_bet_count          : bets accepted this round
//   o_spin_active        : wheel spinning
//   o_bet_ack            : held HOLD_CYCLES after each accept
//   o_bet_reject         : refused bet or spin key
//   o_table_clear        : end-of-round table clear
//   o_round_state        : current state encoding
module bet_round_controller
  import roulette_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned SETTLE_CYCLES = 100_000_000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_key_valid,
  input  logic [OPC_W-1:0]  i_bet_opcode,
  input  logic [CHIP_W-1:0] i_chip_color,
  input  logic              i_spin_done,
  output logic              o_bet_wr_en,
  output logic [IDX_W-1:0]  o_bet_wr_idx,
  output logic [DATA_W-1:0] o_bet_wr_data,
  output logic [IDX_W-1:0]  o_bet_count,
  output logic              o_spin_active,
  output logic              o_bet_ack,
  output logic              o_bet_reject,
  output logic              o_table_clear,
  output logic [1:0]        o_round_state
);

  round_state_e r_state, w_state_nxt;

  logic             r_bet_wr_en, r_spin_active, r_bet_reject, r_table_clear;
  logic [IDX_W-1:0] r_bet_count, r_bet_wr_idx;
  bet_entry_t       r_bet_wr_data;

  logic w_bet_key, w_spin_key, w_has_bets, w_has_room;
  logic w_accept, w_reject, w_spin_go, w_spin_end, w_clear;
  logic w_ack_busy, w_ack_expire_unused;
  logic w_settle_busy_unused, w_settle_expire_c;

  assign w_bet_key  = i_key_valid && (i_bet_opcode < OPC_SPIN);
  assign w_spin_key = i_key_valid && (i_bet_opcode == OPC_SPIN);
  assign w_has_bets = (r_bet_count != '0);
  assign w_has_room = (r_bet_count < IDX_W'(MAX_BETS));

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_BETTING;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; spin_done has priority over any key while spinning.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BETTING:  if (w_spin_key && w_has_bets) w_state_nxt = ST_SPINNING;
      ST_SPINNING: if (i_spin_done)              w_state_nxt = ST_SETTLE;
      ST_SETTLE:   if (w_settle_expire_c)        w_state_nxt = ST_BETTING;
      default:                                   w_state_nxt = ST_BETTING;
    endcase
  end

  // Output decode: events to be registered on this edge.
  always_comb begin
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    w_spin_go  = 1'b0;
    w_spin_end = 1'b0;
    w_clear    = 1'b0;
    case (r_state)
      ST_BETTING: begin
        w_accept  = w_bet_key && i_chip_color[2] && w_has_room;
        w_reject  = (w_bet_key && !(i_chip_color[2] && w_has_room)) ||
                    (w_spin_key && !w_has_bets);
        w_spin_go = w_spin_key && w_has_bets;
      end
      ST_SPINNING: w_spin_end = i_spin_done;
      ST_SETTLE:   w_clear    = w_settle_expire_c;
      default: ;
    endcase
  end

  // Registered outputs and bet datapath.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_bet_wr_en   <= 1'b0;
      r_bet_wr_idx  <= '0;
      r_bet_wr_data <= '0;
      r_bet_count   <= '0;
      r_spin_active <= 1'b0;
      r_bet_reject  <= 1'b0;
      r_table_clear <= 1'b0;
    end else begin
      r_bet_wr_en   <= w_accept;
      r_bet_reject  <= w_reject;
      r_table_clear <= w_clear;
      if (w_accept) begin
        r_bet_wr_idx  <= r_bet_count;
        r_bet_wr_data <= '{amount: i_chip_color[1:0], opcode: i_bet_opcode};
        r_bet_count   <= r_bet_count + IDX_W'(1);
      end else if (w_clear) begin
        r_bet_count <= '0;
      end
      if (w_spin_go)       r_spin_active <= 1'b1;
      else if (w_spin_end) r_spin_active <= 1'b0;
    end
  end

  hold_timer #(.CYCLES(HOLD_CYCLES)) u_ack_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_accept),
    .o_busy     (w_ack_busy),
    .o_expire_c (w_ack_expire_unused)
  );

  // Loaded on the spin_done edge so the settle interval starts in SETTLE.
  hold_timer #(.CYCLES(SETTLE_CYCLES)) u_settle_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_spin_end),
    .o_busy     (w_settle_busy_unused),
    .o_expire_c (w_settle_expire_c)
  );

  assign o_bet_wr_en   = r_bet_wr_en;
  assign o_bet_wr_idx  = r_bet_wr_idx;
  assign o_bet_wr_data = r_bet_wr_data;
  assign o_bet_count   = r_bet_count;
  assign o_spin_active = r_spin_active;
  assign o_bet_ack     = w_ack_busy;
  assign o_bet_reject  = r_bet_reject;
  assign o_table_clear = r_table_clear;
  assign o_round_state = r_state;

endmodule

// File: tb/tb_bet_round_controller.sv
// Self-checking bench for bet_round_controller (HOLD=4, SETTLE=3):
// a directed vector table, hand-written corner sequences, then random
// stimulus against a round-level reference model.
module tb_bet_round_controller;
  import roulette_pkg::*;

  localparam int HOLD   = 4;
  localparam int SETTLE = 3;
  localparam int MAXB   = 12;

  logic       clk;
  logic       rst;
  logic       kv;
  logic [5:0] op;
  logic [2:0] chip;
  logic       sd;

  logic       wr_en, spin_act, ack, rej, clr;
  logic [3:0] wr_idx, cnt;
  logic [7:0] wr_data;
  logic [1:0] st;

  int total = 0;
  int bad   = 0;

  bet_round_controller #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_key_valid   (kv),
    .i_bet_opcode  (op),
    .i_chip_color  (chip),
    .i_spin_done   (sd),
    .o_bet_wr_en   (wr_en),
    .o_bet_wr_idx  (wr_idx),
    .o_bet_wr_data (wr_data),
    .o_bet_count   (cnt),
    .o_spin_active (spin_act),
    .o_bet_ack     (ack),
    .o_bet_reject  (rej),
    .o_table_clear (clr),
    .o_round_state (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: round phase (0 betting, 1 spinning, 2 settle),
  // bets taken, and remaining ack / settle cycles.
  int         m_phase, m_count, m_ack_left, m_settle_left;
  logic       e_wr, e_rej, e_clr;
  int         e_idx;
  logic [7:0] e_data;

  function automatic void model_reset();
    m_phase = 0; m_count = 0; m_ack_left = 0; m_settle_left = 0;
    e_wr = 1'b0; e_rej = 1'b0; e_clr = 1'b0; e_idx = 0; e_data = 8'h00;
  endfunction

  function automatic void model_step();
    bit acc;
    acc = 1'b0;
    e_wr = 1'b0; e_rej = 1'b0; e_clr = 1'b0;
    case (m_phase)
      0: begin
        if (kv && op < 6'd62) begin
          if (chip[2] && m_count < MAXB) begin
            acc = 1'b1; e_wr = 1'b1; e_idx = m_count;
            e_data = {chip[1:0], op}; m_count++;
          end else e_rej = 1'b1;
        end else if (kv && op == 6'd62) begin
          if (m_count > 0) m_phase = 1; else e_rej = 1'b1;
        end
      end
      1: if (sd) begin m_phase = 2; m_settle_left = SETTLE; end
      default: begin
        m_settle_left--;
        if (m_settle_left == 0) begin e_clr = 1'b1; m_count = 0; m_phase = 0; end
      end
    endcase
    if (acc) m_ack_left = HOLD;
    else if (m_ack_left > 0) m_ack_left--;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    cmp({tag, ".wr_en"}, int'(wr_en), int'(e_wr));
    if (e_wr) begin
      cmp({tag, ".wr_idx"}, int'(wr_idx), e_idx);
      cmp({tag, ".wr_data"}, int'(wr_data), int'(e_data));
    end
    cmp({tag, ".count"}, int'(cnt), m_count);
    cmp({tag, ".spin"}, int'(spin_act), int'(m_phase == 1));
    cmp({tag, ".ack"}, int'(ack), int'(m_ack_left > 0));
    cmp({tag, ".reject"}, int'(rej), int'(e_rej));
    cmp({tag, ".clear"}, int'(clr), int'(e_clr));
    cmp({tag, ".state"}, int'(st), m_phase);
  endtask

  task automatic drive(input logic k, input logic [5:0] o, input logic [2:0] c, input logic s);
    kv = k; op = o; chip = c; sd = s;
  endtask

  task automatic cyc_model(input string tag);
    model_step();
    @(posedge clk); #1;
    chk_model(tag);
  endtask

  // Assert reset between edges, check the immediate reset values, release.
  task automatic do_reset(input string tag);
    drive(1'b0, 6'd0, 3'd0, 1'b0);
    rst = 1'b1;
    model_reset();
    #2;
    cmp({tag, ".rst_wr_en"}, int'(wr_en), 0);
    cmp({tag, ".rst_count"}, int'(cnt), 0);
    cmp({tag, ".rst_spin"}, int'(spin_act), 0);
    cmp({tag, ".rst_ack"}, int'(ack), 0);
    cmp({tag, ".rst_reject"}, int'(rej), 0);
    cmp({tag, ".rst_clear"}, int'(clr), 0);
    cmp({tag, ".rst_state"}, int'(st), 0);
    @(posedge clk); #1;
    cmp({tag, ".rst_held_clear"}, int'(clr), 0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic kv; logic [5:0] op; logic [2:0] chip; logic sd;
    logic wr; logic [3:0] idx; logic [7:0] data; logic [3:0] cnt;
    logic spin; logic ack; logic rej; logic clr; logic [1:0] st;
  } vec_t;

  vec_t vt[14];

  initial begin
    rst = 1'b1;
    drive(1'b0, 6'd0, 3'd0, 1'b0);

    //          kv  op     chip    sd   | wr idx data  cnt spin ack rej clr st
    vt[0]  = '{1'b1, 6'd62, 3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[1]  = '{1'b1, 6'd63, 3'b110, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[2]  = '{1'b1, 6'd5,  3'b110, 1'b0, 1'b1, 4'd0, 8'h85, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vt[3]  = '{1'b0, 6'd0,  3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vt[4]  = '{1'b1, 6'd7,  3'b001, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vt[5]  = '{1'b0, 6'd0,  3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vt[6]  = '{1'b0, 6'd0,  3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[7]  = '{1'b1, 6'd62, 3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    vt[8]  = '{1'b1, 6'd3,  3'b111, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    vt[9]  = '{1'b1, 6'd4,  3'b111, 1'b1, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    vt[10] = '{1'b0, 6'd0,  3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    vt[11] = '{1'b0, 6'd0,  3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    vt[12] = '{1'b0, 6'd0,  3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[13] = '{1'b0, 6'd0,  3'b000, 1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    // Power-on reset.
    #2;
    cmp("por.wr_en", int'(wr_en), 0);
    cmp("por.ack", int'(ack), 0);
    cmp("por.state", int'(st), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].kv, vt[i].op, vt[i].chip, vt[i].sd);
      @(posedge clk); #1;
      cmp($sformatf("vec%0d.wr_en", i), int'(wr_en), int'(vt[i].wr));
      if (vt[i].wr) begin
        cmp($sformatf("vec%0d.wr_idx", i), int'(wr_idx), int'(vt[i].idx));
        cmp($sformatf("vec%0d.wr_data", i), int'(wr_data), int'(vt[i].data));
      end
      cmp($sformatf("vec%0d.count", i), int'(cnt), int'(vt[i].cnt));
      cmp($sformatf("vec%0d.spin", i), int'(spin_act), int'(vt[i].spin));
      cmp($sformatf("vec%0d.ack", i), int'(ack), int'(vt[i].ack));
      cmp($sformatf("vec%0d.reject", i), int'(rej), int'(vt[i].rej));
      cmp($sformatf("vec%0d.clear", i), int'(clr), int'(vt[i].clr));
      cmp($sformatf("vec%0d.state", i), int'(st), int'(vt[i].st));
    end

    // Thirteen valid bets: slots 0..11 written, the 13th refused.
    do_reset("fill");
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 6'(i + 10), 3'b101, 1'b0);
      cyc_model($sformatf("fill%0d", i));
      if (i < 12) cmp($sformatf("fill%0d.idx_const", i), int'(wr_idx), i);
      else        cmp("fill12.reject_const", int'(rej), 1);
    end
    cmp("fill.count_sat", int'(cnt), 12);

    // Spin with a full table, then reset mid-SPINNING while ack still holds.
    drive(1'b1, 6'd62, 3'b000, 1'b0);
    cyc_model("spin_full");
    cmp("spin_full.ack_held", int'(ack), 1);
    do_reset("mid_spin");
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 6'd0, 3'd0, 1'b0);
      cyc_model($sformatf("post_rst%0d", i));
    end

    // Random rounds against the model.
    do_reset("rand");
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] r_op;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3)       r_op = 6'd62;
      else if (sel == 3) r_op = 6'd63;
      else               r_op = 6'($urandom_range(0, 61));
      drive(1'($urandom_range(0, 99) < 60), r_op, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 14) == 0));
      cyc_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
